// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: funct3 access encodings,
// FSM state codes and the low-address masking helper.
package mem_stage_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Halfwords keep only off[1]; words ignore the offset entirely.
  function automatic logic [1:0] eff_off(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return off;
      2'b01:   return {off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load extraction: selects the byte/half addressed by off from a read word
// and sign- or zero-extends it according to funct3.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = '0;
    case (off)
      2'd0: b = rdata[7:0];
      2'd1: b = rdata[15:8];
      2'd2: b = rdata[23:16];
      2'd3: b = rdata[31:24];
      default: b = '0;
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data = rdata;
    case (funct3)
      F3_LB:   data = {{24{b[7]}}, b};
      F3_LH:   data = {{16{h[15]}}, h};
      F3_LBU:  data = {24'd0, b};
      F3_LHU:  data = {16'd0, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: req/gnt/rvalid data-bus FSM, store lane alignment,
// load extraction and the MEM/WB register. Optional misaligned-access trap
// is enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_i,
  input  logic                   MemRead_i,
  input  logic                   MemWrite_i,
  input  logic [2:0]             funct3_i,
  input  logic [XLEN-1:0]        result_i,
  input  logic [XLEN-1:0]        store_data_i,
  input  logic                   RegWrite_i,
  input  logic [4:0]             Rd_i,
  output logic                   dmem_req_o,
  output logic                   dmem_we_o,
  output logic [3:0]             dmem_be_o,
  output logic [XLEN-1:0]        dmem_addr_o,
  output logic [XLEN-1:0]        dmem_wdata_o,
  input  logic                   dmem_gnt_i,
  input  logic                   dmem_rvalid_i,
  input  logic [XLEN-1:0]        dmem_rdata_i,
  output logic                   mem_stall_o,
  output logic [XLEN-1:0]        load_or_result_o,
  output logic [4:0]             Rd_o,
  output logic                   RegWrite_o,
  output logic                   misalign_o,
  output logic [STALL_CNT_W-1:0] stall_cycles_o
);

  state_t           state, state_nx;
  logic [1:0]       off, off_eff;
  logic             misaligned, mem_op, is_store, complete;
  logic [XLEN-1:0]  load_data;

  assign off     = result_i[1:0];
  assign off_eff = eff_off(funct3_i, off);

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = ((funct3_i[1:0] == 2'b01) && off[0]) ||
                      ((funct3_i[1:0] == 2'b10) && (off != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign mem_op   = valid_i & (MemRead_i | MemWrite_i) & ~misaligned;
  assign is_store = MemWrite_i;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (mem_op) begin
        if (dmem_gnt_i) state_nx = is_store ? ST_IDLE : ST_WAIT;
        else            state_nx = ST_REQ;
      end
      ST_REQ:  if (dmem_gnt_i) state_nx = is_store ? ST_IDLE : ST_WAIT;
      ST_WAIT: if (dmem_rvalid_i) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    dmem_req_o  = ((state == ST_IDLE) & mem_op) | (state == ST_REQ);
    complete    = (dmem_req_o & dmem_gnt_i & is_store) |
                  ((state == ST_WAIT) & dmem_rvalid_i);
    mem_stall_o = (mem_op | (state != ST_IDLE)) & ~complete;
  end

  assign dmem_we_o   = is_store;
  assign dmem_addr_o = {result_i[XLEN-1:2], 2'b00};

  always_comb begin
    dmem_be_o    = 4'b1111;
    dmem_wdata_o = store_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        dmem_be_o    = 4'b0001 << off_eff;
        dmem_wdata_o = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        dmem_be_o    = 4'b0011 << off_eff;
        dmem_wdata_o = {2{store_data_i[15:0]}};
      end
      default: begin
        dmem_be_o    = 4'b1111;
        dmem_wdata_o = store_data_i;
      end
    endcase
  end

  load_align u_load_align (
    .rdata  (dmem_rdata_i),
    .off    (off_eff),
    .funct3 (funct3_i),
    .data   (load_data)
  );

  // MEM/WB holds while stalled; a load only reaches here in its rvalid cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_or_result_o <= '0;
      Rd_o             <= '0;
      RegWrite_o       <= 1'b0;
    end else if (!mem_stall_o) begin
      load_or_result_o <= (valid_i & MemRead_i & ~MemWrite_i & ~misaligned) ? load_data : result_i;
      Rd_o             <= Rd_i;
      RegWrite_o       <= valid_i & RegWrite_i & (Rd_i != 5'd0) & ~MemWrite_i & ~misaligned;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                                   stall_cycles_o <= '0;
    else if (mem_stall_o && (stall_cycles_o != '1)) stall_cycles_o <= stall_cycles_o + 1'b1;
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_q;
  always_ff @(posedge clk) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= valid_i & (MemRead_i | MemWrite_i) & misaligned;
  end
  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected MEM/WB contents,
// a monitor pops and compares on every committed (non-stalled, valid) cycle.
module tb_mem_stage;

  logic        clk, rst_n;
  logic        valid_i, MemRead_i, MemWrite_i, RegWrite_i;
  logic [2:0]  funct3_i;
  logic [31:0] result_i, store_data_i, dmem_rdata_i;
  logic [4:0]  Rd_i, Rd_o;
  logic        dmem_req_o, dmem_we_o, dmem_gnt_i, dmem_rvalid_i;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, load_or_result_o;
  logic        mem_stall_o, RegWrite_o, misalign_o;
  logic [15:0] stall_cycles_o;

  mem_stage #(.XLEN(32), .STALL_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .funct3_i(funct3_i), .result_i(result_i),
    .store_data_i(store_data_i), .RegWrite_i(RegWrite_i), .Rd_i(Rd_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i),
    .dmem_rdata_i(dmem_rdata_i), .mem_stall_o(mem_stall_o),
    .load_or_result_o(load_or_result_o), .Rd_o(Rd_o), .RegWrite_o(RegWrite_o),
    .misalign_o(misalign_o), .stall_cycles_o(stall_cycles_o)
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rw;
    logic        chk_data;
  } wb_t;

  wb_t sb[$];
  int  total = 0;
  int  bad = 0;
  int  exp_stall = 0;
  bit  commit = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: decides commit mid-cycle, compares registered outputs at the next negedge.
  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      if (commit) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL wb_unexpected: got commit rd=%0d expected none", Rd_o);
        end else begin
          e = sb.pop_front();
          chk("wb_rd", {27'd0, Rd_o}, {27'd0, e.rd});
          chk("wb_rw", {31'd0, RegWrite_o}, {31'd0, e.rw});
          if (e.chk_data) chk("wb_data", load_or_result_o, e.data);
        end
      end
      #3;
      commit = rst_n && valid_i && !mem_stall_o;
    end
  end

  task automatic idle_inputs();
    valid_i = 0; MemRead_i = 0; MemWrite_i = 0; RegWrite_i = 0;
    funct3_i = '0; result_i = '0; store_data_i = '0; Rd_i = '0;
  endtask

  task automatic issue(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [4:0] rd, input logic rw);
    valid_i = 1; MemRead_i = rd_op; MemWrite_i = wr_op; funct3_i = f3;
    result_i = addr; store_data_i = sdata; Rd_i = rd; RegWrite_i = rw;
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] rd, input int gnt_delay,
                          input logic [3:0] exp_be, input logic [31:0] exp_addr,
                          input logic [31:0] exp_wdata);
    int stalls = 0;
    @(negedge clk);
    issue(0, 1, f3, addr, sdata, rd, 1);
    sb.push_back('{addr, rd, 1'b0, 1'b0});
    for (int i = 0; i < gnt_delay; i++) begin
      #1;
      if (mem_stall_o) stalls++;
      chk("st_hold_addr", dmem_addr_o, exp_addr);
      chk("st_hold_be", {28'd0, dmem_be_o}, {28'd0, exp_be});
      @(negedge clk);
    end
    dmem_gnt_i = 1;
    #1;
    chk("st_req", {31'd0, dmem_req_o}, 32'd1);
    chk("st_we", {31'd0, dmem_we_o}, 32'd1);
    chk("st_addr", dmem_addr_o, exp_addr);
    chk("st_be", {28'd0, dmem_be_o}, {28'd0, exp_be});
    chk("st_wdata", dmem_wdata_o, exp_wdata);
    chk("st_stall_done", {31'd0, mem_stall_o}, 32'd0);
    @(negedge clk);
    dmem_gnt_i = 0;
    idle_inputs();
    exp_stall += gnt_delay;
    chk("st_stalls", stalls, gnt_delay);
    chk("stall_cnt", {16'd0, stall_cycles_o}, exp_stall);
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                         input logic rw, input logic [31:0] rdata,
                         input int gnt_delay, input int rv_delay,
                         input logic [3:0] exp_be, input logic [31:0] exp_addr,
                         input logic [31:0] exp_data, input logic exp_rw);
    int stalls = 0;
    @(negedge clk);
    issue(1, 0, f3, addr, 32'h0, rd, rw);
    sb.push_back('{exp_data, rd, exp_rw, 1'b1});
    for (int i = 0; i < gnt_delay; i++) begin
      #1;
      if (mem_stall_o) stalls++;
      @(negedge clk);
    end
    dmem_gnt_i = 1;
    #1;
    if (mem_stall_o) stalls++;
    chk("ld_req", {31'd0, dmem_req_o}, 32'd1);
    chk("ld_we", {31'd0, dmem_we_o}, 32'd0);
    chk("ld_addr", dmem_addr_o, exp_addr);
    chk("ld_be", {28'd0, dmem_be_o}, {28'd0, exp_be});
    @(negedge clk);
    dmem_gnt_i = 0;
    for (int i = 1; i < rv_delay; i++) begin
      #1;
      if (mem_stall_o) stalls++;
      @(negedge clk);
    end
    dmem_rvalid_i = 1;
    dmem_rdata_i = rdata;
    #1;
    chk("ld_stall_done", {31'd0, mem_stall_o}, 32'd0);
    @(negedge clk);
    dmem_rvalid_i = 0;
    dmem_rdata_i = '0;
    idle_inputs();
    exp_stall += gnt_delay + rv_delay;
    chk("ld_stalls", stalls, gnt_delay + rv_delay);
    chk("stall_cnt", {16'd0, stall_cycles_o}, exp_stall);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0;
    dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = '0;
    idle_inputs();
    repeat (3) @(negedge clk);
    chk("rst_req", {31'd0, dmem_req_o}, 32'd0);
    chk("rst_stall", {31'd0, mem_stall_o}, 32'd0);
    chk("rst_lor", load_or_result_o, 32'd0);
    chk("rst_rd", {27'd0, Rd_o}, 32'd0);
    chk("rst_rw", {31'd0, RegWrite_o}, 32'd0);
    chk("rst_cnt", {16'd0, stall_cycles_o}, 32'd0);
    chk("rst_mis", {31'd0, misalign_o}, 32'd0);
    rst_n = 1;
    @(negedge clk);

    // Non-memory op
    @(negedge clk);
    issue(0, 0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1);
    sb.push_back('{32'h0000_1234, 5'd5, 1'b1, 1'b1});
    #1 chk("alu_stall", {31'd0, mem_stall_o}, 32'd0);
    chk("alu_req", {31'd0, dmem_req_o}, 32'd0);
    @(negedge clk);
    idle_inputs();

    do_store(3'b000, 32'h0000_0102, 32'h0000_00AB, 5'd7, 3, 4'b0100, 32'h100, 32'hABAB_ABAB);
    do_load (3'b000, 32'h0000_0203, 5'd9,  1, 32'h8000_0000, 0, 2, 4'b1000, 32'h200, 32'hFFFF_FF80, 1);
    do_load (3'b100, 32'h0000_0203, 5'd10, 1, 32'h8000_0000, 0, 2, 4'b1000, 32'h200, 32'h0000_0080, 1);
    do_load (3'b001, 32'h0000_0302, 5'd11, 1, 32'h7FFF_0000, 1, 1, 4'b1100, 32'h300, 32'h0000_7FFF, 1);
    do_load (3'b010, 32'h0000_0500, 5'd0,  1, 32'h1234_5678, 0, 1, 4'b1111, 32'h500, 32'h1234_5678, 0);
    do_store(3'b001, 32'h0000_0602, 32'h1234_BEEF, 5'd12, 0, 4'b1100, 32'h600, 32'hBEEF_BEEF);
    do_store(3'b010, 32'h0000_0700, 32'h89AB_CDEF, 5'd13, 1, 4'b1111, 32'h700, 32'h89AB_CDEF);
    do_load (3'b101, 32'h0000_0802, 5'd14, 1, 32'h8001_0000, 0, 1, 4'b1100, 32'h800, 32'h0000_8001, 1);

    // Reset while waiting for rvalid; rvalid arriving afterwards is ignored
    @(negedge clk);
    issue(1, 0, 3'b010, 32'h0000_0400, 32'h0, 5'd3, 1);
    dmem_gnt_i = 1;
    @(negedge clk);
    dmem_gnt_i = 0;
    #1 chk("wait_stall", {31'd0, mem_stall_o}, 32'd1);
    @(negedge clk);
    rst_n = 0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    exp_stall = 0;
    @(negedge clk);
    dmem_rvalid_i = 1;
    dmem_rdata_i = 32'hDEAD_BEEF;
    #1 chk("rr_req", {31'd0, dmem_req_o}, 32'd0);
    chk("rr_stall", {31'd0, mem_stall_o}, 32'd0);
    @(negedge clk);
    dmem_rvalid_i = 0;
    dmem_rdata_i = '0;
    chk("rr_lor", load_or_result_o, 32'd0);
    chk("rr_rw", {31'd0, RegWrite_o}, 32'd0);
    chk("rr_rd", {27'd0, Rd_o}, 32'd0);
    chk("rr_cnt", {16'd0, stall_cycles_o}, 32'd0);

    do_load(3'b000, 32'h0000_0901, 5'd15, 1, 32'h0000_7F00, 0, 1, 4'b0010, 32'h900, 32'h0000_007F, 1);

`ifdef MEM_MISALIGN_TRAP_EN
    @(negedge clk);
    issue(1, 0, 3'b010, 32'h0000_0102, 32'h0, 5'd4, 1);
    sb.push_back('{32'h0, 5'd4, 1'b0, 1'b0});
    #1 chk("mis_req", {31'd0, dmem_req_o}, 32'd0);
    chk("mis_stall", {31'd0, mem_stall_o}, 32'd0);
    @(negedge clk);
    idle_inputs();
    chk("mis_flag", {31'd0, misalign_o}, 32'd1);
    @(negedge clk);
    chk("mis_pulse_end", {31'd0, misalign_o}, 32'd0);
`else
    do_load(3'b010, 32'h0000_0102, 5'd4, 1, 32'hCAFE_F00D, 0, 1, 4'b1111, 32'h100, 32'hCAFE_F00D, 1);
    chk("mis_tied", {31'd0, misalign_o}, 32'd0);
`endif

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage; consumes the EX/MEM register contents (ALU result as address, forwarded store data, control).
- Drives a req/gnt/rvalid data-bus handshake, performs byte/half/word store lane alignment and load extraction with sign/zero extension.
- Owns the MEM/WB pipeline register, whose output feeds the forwarding path and writeback as load_or_result.
- Raises a stall to the whole pipeline while a memory access is outstanding.

Parameters:
- XLEN, 32, datapath width; only 32 supported.
- STALL_CNT_W, 16, width of the saturating stall-cycle performance counter.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- valid_i  input  1  instruction present in MEM
- MemRead_i  input  1  load
- MemWrite_i  input  1  store
- funct3_i  input  3  access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
- result_i  input  32  ALU result; address for loads/stores, writeback value otherwise
- store_data_i  input  32  forwarded Rs2 data
- RegWrite_i  input  1  register write enable
- Rd_i  input  5  destination register
- dmem_req_o  output  1  bus request
- dmem_we_o  output  1  1 = write
- dmem_be_o  output  4  byte enables
- dmem_addr_o  output  32  word-aligned address ({result_i[31:2],2'b00})
- dmem_wdata_o  output  32  lane-shifted store data
- dmem_gnt_i  input  1  request accepted
- dmem_rvalid_i  input  1  read data valid
- dmem_rdata_i  input  32  read data
- mem_stall_o  output  1  freeze all upstream stages
- load_or_result_o  output  32  MEM/WB data
- Rd_o  output  5  MEM/WB destination
- RegWrite_o  output  1  MEM/WB write enable
- misalign_o  output  1  misaligned access flag (see Optional Feature)
- stall_cycles_o  output  STALL_CNT_W  saturating count of cycles with mem_stall_o=1

Behaviour:
- Reset: state IDLE; all registered outputs 0; dmem_req_o=0; stall_cycles_o=0. Reset mid-access abandons the access. An rvalid arriving in IDLE is ignored.
- FSM states and transitions:
  - IDLE: on valid_i & (MemRead_i | MemWrite_i), assert dmem_req_o the same cycle and go to REQ unless dmem_gnt_i is already high.
  - REQ: hold dmem_req_o with address, we, be and wdata stable until dmem_gnt_i. On gnt, a store goes to IDLE and completes; a load goes to WAIT.
  - WAIT: hold until dmem_rvalid_i, then complete and go to IDLE.
  - rvalid never arrives in the gnt cycle; the earliest is gnt+1.
- mem_stall_o: combinational; 1 whenever a memory op is in the stage and not completing this cycle. 0 in the completion cycle. Upstream holds all *_i inputs stable while stalled.
- Latency:
  - Non-memory ops: the MEM/WB register captures result_i, Rd_i, RegWrite_i on the next edge; no stall.
  - Store: completes in the gnt cycle.
  - Load: completes in the rvalid cycle, with data registered at that edge.
- MEM/WB update: if valid_i=0, the register captures RegWrite=0. RegWrite_o is forced 0 when Rd_i=0. A store writes RegWrite_o=0.
- Store lanes, with off = result_i[1:0]:
  - SB: be = 4'b0001<<off; wdata = {4{byte}}.
  - SH: be = 4'b0011<<{off[1],1'b0}; wdata = {2{half}}.
  - SW: be = 4'b1111; wdata = store_data_i.
- Load extraction from rdata using off:
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: pass through.
- stall_cycles_o increments each stalled cycle and saturates at all-ones.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- Defined:
  - A halfword with off[0]=1, or a word with off!=0, issues no bus request and produces no stall.
  - misalign_o pulses for 1 cycle (registered) and the MEM/WB register captures RegWrite=0.
- Undefined:
  - Low address bits are masked (half uses off[1] only; word ignores off).
  - The access proceeds aligned; misalign_o is tied 0.

Decomposition:
- Add the funct3 encodings (LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010) and the FSM state codes to define.v.
- One combinational sub-module, load_align (rdata, off, funct3 -> 32-bit extended value), so it can be reused and unit-tested.

Test Plan:
- Non-mem op, result_i=32'h0000_1234, Rd=5, RegWrite=1 -> next cycle load_or_result_o=32'h1234, Rd_o=5, RegWrite_o=1; mem_stall_o never 1.
- SB, addr=32'h100 + off 2, store_data=32'hAB -> dmem_addr=32'h100, be=4'b0100, wdata=32'hABABABAB. gnt delayed 3 cycles -> mem_stall_o high exactly 3 cycles; stall_cycles_o=3.
- LB, off=3, rdata=32'h80_00_00_00, gnt immediate, rvalid 2 cycles later -> load_or_result_o=32'hFFFFFF80. LBU on the same data -> 32'h00000080.
- LH, off=2, rdata=32'h7FFF_0000 -> 32'h00007FFF. LW with Rd=0 -> RegWrite_o=0.
- Reset asserted while in WAIT, with rvalid arriving 1 cycle after reset release -> state IDLE, req=0, rvalid ignored, outputs 0.
- LW at addr 32'h102:
  - With MEM_MISALIGN_TRAP_EN: no dmem_req_o, misalign_o=1 for one cycle, RegWrite_o=0.
  - Without it: access to 32'h100 with be=4'b1111.
